// File: rtl/hlsm_result_fifo.sv
// Result FIFO behind the scheduled HLSM: captures {j,l} on each Done rising edge and
// presents entries to the consumer over valid/ready, counting results lost when full.
module hlsm_result_fifo #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DROP_W = 8
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Done,
  input  logic [WIDTH-1:0]         j,
  input  logic [WIDTH-1:0]         l,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [WIDTH-1:0]         OutJ,
  output logic [WIDTH-1:0]         OutL,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow,
  output logic [DROP_W-1:0]        DropCnt,
  input  logic                     ClrOvf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  logic [WIDTH-1:0]  r_mem_j [DEPTH];
  logic [WIDTH-1:0]  r_mem_l [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic              r_done_q;
  logic              r_ovf;
  logic [DROP_W-1:0] r_drop;
  logic [WIDTH-1:0]  r_out_j;
  logic [WIDTH-1:0]  r_out_l;

  logic              w_push_req;
  logic              w_pop;
  logic              w_full;
  logic              w_accept;
  logic              w_drop;
  logic [AW-1:0]     w_rptr_d;
  logic [AW-1:0]     w_wptr_d;
  logic [AW:0]       w_count_d;

  always_comb begin
    w_push_req = Done & ~r_done_q;
    w_pop      = (r_count != '0) & OutReady;
    w_full     = (r_count == FullCnt);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    w_accept   = w_push_req & (~w_full | w_pop);
    w_drop     = w_push_req & w_full & ~w_pop;
    w_rptr_d   = w_pop ? r_rptr + AW'(1) : r_rptr;
    w_wptr_d   = w_accept ? r_wptr + AW'(1) : r_wptr;
    w_count_d  = r_count;
    if (w_accept && !w_pop) begin
      w_count_d = r_count + (AW+1)'(1);
    end else if (w_pop && !w_accept) begin
      w_count_d = r_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_mem_j[r_wptr] <= j;
      r_mem_l[r_wptr] <= l;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_done_q <= 1'b1;
      r_ovf    <= 1'b0;
      r_drop   <= '0;
      r_out_j  <= '0;
      r_out_l  <= '0;
    end else begin
      r_wptr   <= w_wptr_d;
      r_rptr   <= w_rptr_d;
      r_count  <= w_count_d;
      r_done_q <= Done;
      if (w_drop) begin
        r_ovf  <= 1'b1;
        r_drop <= ClrOvf ? DROP_W'(1) : ((&r_drop) ? r_drop : r_drop + DROP_W'(1));
      end else if (ClrOvf) begin
        r_ovf  <= 1'b0;
        r_drop <= '0;
      end
      // Head register loads the next head; a write landing on it this cycle is forwarded.
      if (w_count_d != '0) begin
        if (w_accept && (r_wptr == w_rptr_d)) begin
          r_out_j <= j;
          r_out_l <= l;
        end else begin
          r_out_j <= r_mem_j[w_rptr_d];
          r_out_l <= r_mem_l[w_rptr_d];
        end
      end
    end
  end

  assign OutValid = (r_count != '0);
  assign OutJ     = r_out_j;
  assign OutL     = r_out_l;
  assign Count    = r_count;
  assign Overflow = r_ovf;
  assign DropCnt  = r_drop;

endmodule

// File: tb/tb_hlsm_result_fifo.sv
// Randomised and directed bench for hlsm_result_fifo against a queue-based reference model.
module tb_hlsm_result_fifo;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DROP_W = 8;
  localparam int          DropMax = (1 << DROP_W) - 1;

  logic                   Clk;
  logic                   Rst;
  logic                   Done;
  logic [WIDTH-1:0]       j;
  logic [WIDTH-1:0]       l;
  logic                   OutValid;
  logic                   OutReady;
  logic [WIDTH-1:0]       OutJ;
  logic [WIDTH-1:0]       OutL;
  logic [$clog2(DEPTH):0] Count;
  logic                   Overflow;
  logic [DROP_W-1:0]      DropCnt;
  logic                   ClrOvf;

  hlsm_result_fifo #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) u_dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Done     (Done),
    .j        (j),
    .l        (l),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutJ     (OutJ),
    .OutL     (OutL),
    .Count    (Count),
    .Overflow (Overflow),
    .DropCnt  (DropCnt),
    .ClrOvf   (ClrOvf)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [2*WIDTH-1:0] m_q[$];
  logic               m_done;
  logic               m_ovf;
  int                 m_drop;
  logic [WIDTH-1:0]   m_j;
  logic [WIDTH-1:0]   m_l;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_done = 1'b1;
    m_ovf  = 1'b0;
    m_drop = 0;
    m_j    = '0;
    m_l    = '0;
  endtask

  task automatic model_edge();
    logic push_req, pop, full, drop;
    if (!Rst) begin
      model_reset();
      return;
    end
    push_req = Done && !m_done;
    pop      = (m_q.size() > 0) && OutReady;
    full     = (m_q.size() == DEPTH);
    drop     = push_req && full && !pop;
    if (pop) void'(m_q.pop_front());
    if (push_req && !drop) m_q.push_back({j, l});
    if (drop) begin
      m_ovf  = 1'b1;
      m_drop = ClrOvf ? 1 : ((m_drop == DropMax) ? DropMax : m_drop + 1);
    end else if (ClrOvf) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    m_done = Done;
    if (m_q.size() > 0) {m_j, m_l} = m_q[0];
  endtask

  task automatic check_all();
    check("count",    32'(Count),    32'(m_q.size()));
    check("valid",    32'(OutValid), 32'(m_q.size() != 0));
    check("out_j",    32'(OutJ),     32'(m_j));
    check("out_l",    32'(OutL),     32'(m_l));
    check("overflow", 32'(Overflow), 32'(m_ovf));
    check("dropcnt",  32'(DropCnt),  32'(m_drop));
  endtask

  // Inputs change #1 after the edge; outputs are checked at the same point.
  task automatic cycle();
    @(posedge Clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic pulse(input logic [WIDTH-1:0] pj, input logic [WIDTH-1:0] pl,
                       input logic ready);
    Done = 1'b1; j = pj; l = pl; OutReady = ready;
    cycle();
    Done = 1'b0; OutReady = 1'b0;
    cycle();
  endtask

  task automatic drain();
    OutReady = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) cycle();
    OutReady = 1'b0;
  endtask

  task automatic clear_ovf();
    ClrOvf = 1'b1;
    cycle();
    ClrOvf = 1'b0;
  endtask

  initial begin
    Rst = 1'b0; Done = 1'b1; j = '0; l = '0; OutReady = 1'b0; ClrOvf = 1'b0;
    model_reset();
    #1;
    check_all();
    cycle();
    cycle();

    // Done already high at reset release is never captured.
    Rst = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    check("no_push_cnt", 32'(Count), 32'd0);
    check("no_push_vld", 32'(OutValid), 32'd0);

    Done = 1'b0;
    cycle();
    Done = 1'b1; j = 16'sd7; l = -16'sd3;
    cycle();
    check("first_vld", 32'(OutValid), 32'd1);
    check("first_j",   32'(OutJ), 32'd7);
    check("first_l",   32'(OutL), 32'h0000_FFFD);
    check("first_cnt", 32'(Count), 32'd1);
    Done = 1'b0;
    cycle();
    drain();

    // Fill, then one more pulse is dropped.
    for (int k = 1; k <= 4; k++) pulse(WIDTH'(k), WIDTH'(100 + k), 1'b0);
    pulse(16'd5, 16'd105, 1'b0);
    check("full_cnt",  32'(Count), 32'd4);
    check("full_ovf",  32'(Overflow), 32'd1);
    check("full_drop", 32'(DropCnt), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      check("drain_j", 32'(OutJ), 32'(k));
      OutReady = 1'b1;
      cycle();
    end
    OutReady = 1'b0;
    check("drain_empty", 32'(OutValid), 32'd0);
    clear_ovf();

    // Push coincident with pop on a full FIFO is accepted.
    for (int k = 1; k <= 4; k++) pulse(WIDTH'(k), 16'd0, 1'b0);
    check("pp_head", 32'(OutJ), 32'd1);
    pulse(16'd5, 16'd0, 1'b1);
    check("pp_cnt",  32'(Count), 32'd4);
    check("pp_drop", 32'(DropCnt), 32'd0);
    for (int k = 2; k <= 5; k++) begin
      check("pp_j", 32'(OutJ), 32'(k));
      OutReady = 1'b1;
      cycle();
    end
    OutReady = 1'b0;

    // Saturation and clear behaviour.
    for (int k = 0; k < 4; k++) pulse(WIDTH'(k), 16'd0, 1'b0);
    for (int k = 0; k < 300; k++) pulse(16'hAAAA, 16'h5555, 1'b0);
    check("sat_drop", 32'(DropCnt), 32'd255);
    clear_ovf();
    check("clr_ovf",  32'(Overflow), 32'd0);
    check("clr_drop", 32'(DropCnt), 32'd0);
    pulse(16'd9, 16'd9, 1'b0);
    Done = 1'b1; ClrOvf = 1'b1;
    cycle();
    Done = 1'b0; ClrOvf = 1'b0;
    check("clr_vs_drop_ovf", 32'(Overflow), 32'd1);
    check("clr_vs_drop_cnt", 32'(DropCnt), 32'd1);
    cycle();
    drain();
    clear_ovf();

    // Asynchronous reset mid-cycle with three entries buffered.
    for (int k = 1; k <= 3; k++) pulse(WIDTH'(k + 20), 16'd1, 1'b0);
    check("pre_rst_cnt", 32'(Count), 32'd3);
    Done = 1'b1;
    #2;
    Rst = 1'b0;
    #1;
    model_reset();
    check("arst_cnt", 32'(Count), 32'd0);
    check("arst_vld", 32'(OutValid), 32'd0);
    check("arst_j",   32'(OutJ), 32'd0);
    cycle();
    Rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    Done = 1'b0;
    cycle();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      Done     = ($urandom_range(0, 2) != 0) ? ~Done : Done;
      j        = WIDTH'($urandom);
      l        = WIDTH'($urandom);
      OutReady = ($urandom_range(0, 2) == 0);
      ClrOvf   = ($urandom_range(0, 24) == 0);
      Rst      = ($urandom_range(0, 299) != 0);
      cycle();
    end
    Rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hlsm_result_fifo.md
Name: hlsm_result_fifo

Overview:
- Downstream stage of the scheduled HLSM datapath. It consumes the HLSM's Done/j/l outputs.
- Detects each Done rising edge and captures the signed j/l result pair into a small FIFO.
- Presents buffered results to the consumer over a valid/ready handshake.
- Flags and counts results that are lost when the FIFO is full.

Parameters:
- WIDTH, 16, bit width of each signed result word (j, l).
- DEPTH, 4, number of FIFO entries; must be a power of two, minimum 2.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- Clk  input  1  system clock, rising-edge active.
- Rst  input  1  reset; asynchronous assert, active-low (0 = reset).
- Done  input  1  HLSM Done level; held high from the last schedule state until the next Start.
- j  input  WIDTH  HLSM result j, signed; stable while Done=1.
- l  input  WIDTH  HLSM result l, signed; stable while Done=1.
- OutValid  output  1  head entry available.
- OutReady  input  1  consumer accepts head entry this cycle.
- OutJ  output  WIDTH  head entry j, signed.
- OutL  output  WIDTH  head entry l, signed.
- Count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- Overflow  output  1  sticky flag: at least one result dropped.
- DropCnt  output  DROP_W  number of dropped results, saturating.
- ClrOvf  input  1  synchronous clear of Overflow and DropCnt.

Behaviour:
- Reset (Rst=0, asynchronous):
  - Count=0, OutValid=0, OutJ=0, OutL=0, Overflow=0, DropCnt=0.
  - Read/write pointers = 0.
  - Done edge register done_q = 1. A Done already high (or X) when reset releases is never captured; capture is armed only after Done has been sampled 0.
- Edge detect:
  - push_req = Done & ~done_q.
  - done_q <= Done every cycle.
  - A Done level held high for many cycles generates exactly one push.
- Push: on a push_req cycle, {j,l} sampled at that rising edge is written to the write pointer, provided the entry is accepted (see full handling below).
- Output, first-word-fall-through:
  - OutValid = (Count != 0).
  - OutJ/OutL = entry at the read pointer, registered; they hold their last value when empty.
  - Pop occurs when OutValid & OutReady.
- Latency: push at edge N gives OutValid=1 with that data in the cycle after edge N. An empty FIFO does not bypass.
- Pointers: log2(DEPTH) bits, natural wrap from DEPTH-1 to 0.
- Count:
  - +1 on accepted push only.
  - -1 on pop only.
  - Unchanged on simultaneous accepted push and pop.
- Full handling:
  - Full, push_req and pop in the same cycle: the push is accepted, Count stays DEPTH, no drop.
  - Full, push_req and no pop: the result is dropped. Overflow <= 1; DropCnt increments and saturates at 2^DROP_W-1; FIFO contents unchanged.
- Empty: OutReady with OutValid=0 is ignored; no pointer or Count change.
- ClrOvf:
  - Clears Overflow and DropCnt next edge.
  - If a drop occurs in the same cycle, the drop wins: Overflow=1, DropCnt=1.
- Arithmetic: data is passed bit-exact with no sign manipulation. DropCnt is unsigned.
- Reset mid-operation: all entries are discarded immediately and outputs take their reset values. A Done still high after release is not captured (done_q=1).

Test Plan:
- Reset with Done=1, release, hold Done=1 for 5 cycles -> no push, Count=0, OutValid=0.
- Done 0->1 with j=16'sd7, l=-16'sd3, OutReady=0 -> next cycle OutValid=1, OutJ=7, OutL=0xFFFD, Count=1.
- Four Done pulses (j=1..4), OutReady=0, then a fifth pulse -> Count=4, Overflow=1, DropCnt=1. Then OutReady=1 for 4 cycles -> OutJ=1,2,3,4, then OutValid=0.
- FIFO full, fifth Done edge coincident with OutReady=1 -> no drop, Count stays 4, OutJ sequence 1,2,3,4,5.
- 300 Done pulses into a full FIFO with OutReady=0 -> DropCnt=255 (saturated). ClrOvf=1 with no drop -> Overflow=0, DropCnt=0. ClrOvf=1 coincident with a drop -> Overflow=1, DropCnt=1.
- Count=3, assert Rst=0 asynchronously mid-cycle -> Count=0, OutValid=0, OutJ=0 immediately, before the next clock edge.
